alu_sequencer: RTL and testbench



---
 rtl/salamander_pkg.sv | 46 ++++
 rtl/alu_seq_decode.sv | 29 ++
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/salamander_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, decode bundle.
package salamander_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JNZ = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } seq_state_t;

    typedef struct packed {
        logic needs_mem;
        logic writes_acc;
        logic updates_c;
        logic is_jump;
        logic is_halt;
    } dec_t;

    // Ops whose right operand comes from data memory (extra MEM cycle).
    function automatic logic needs_mem_operand(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LD: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder for the ALU sequencer.
module alu_seq_decode
    import salamander_pkg::*;
(
    input  logic [3:0] i_op,
    output dec_t       o_dec
);

    // Classify the opcode into the control bundle used by the FSM.
    always_comb begin
        o_dec           = '0;
        o_dec.needs_mem = needs_mem_operand(i_op);
        case (i_op)
            OP_ADD, OP_SUB: begin
                o_dec.writes_acc = 1'b1;
                o_dec.updates_c  = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LD,
            OP_INC, OP_DEC, OP_SHL, OP_SHR:
                o_dec.writes_acc = 1'b1;
            OP_JZ, OP_JNZ:
                o_dec.is_jump = 1'b1;
            OP_HLT:
                o_dec.is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving an external 8-bit ALU from sync instruction/data memories.
// Optional macro SALAMANDER_CARRY_CHAIN_EN: feeds the C flag into alu_carry_in on ADD/SUB
// so multi-precision sums can be chained; otherwise the carry input is tied low.
module alu_sequencer
    import salamander_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    output logic               busy,
    output logic               halted,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic               dmem_rd,
    output logic               dmem_wr,
    output logic [SIZE-1:0]    dmem_wdata,
    input  logic [SIZE-1:0]    dmem_rdata,
    output logic               alu_ce,
    output logic [3:0]         alu_op,
    output logic [SIZE-1:0]    alu_left,
    output logic [SIZE-1:0]    alu_right,
    output logic               alu_carry_in,
    input  logic [SIZE-1:0]    alu_result,
    input  logic               alu_carry_out,
    output logic [SIZE-1:0]    acc,
    output logic [ADDR_W-1:0]  pc
);

    seq_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [SIZE-1:0]    r_acc;
    logic [INSTR_W-1:0] r_ir;
    logic [SIZE-1:0]    r_opnd;
    logic               r_z, r_c;

    logic               w_in_decode, w_exec, w_jump_taken;
    logic [3:0]         w_op;
    logic [ADDR_W-1:0]  w_imm, w_pc_inc;
    dec_t               w_dec;
    // Reserved instruction bits and (in the default build) C are intentionally not consumed.
    logic               w_unused;

    assign w_in_decode = (r_state == S_DECODE);
    assign w_exec      = (r_state == S_EXEC);
    // In DECODE the instruction is still on the memory bus; afterwards it lives in IR.
    assign w_op        = w_in_decode ? imem_rdata[INSTR_W-1 -: 4] : r_ir[INSTR_W-1 -: 4];
    assign w_imm       = w_in_decode ? imem_rdata[ADDR_W-1:0]     : r_ir[ADDR_W-1:0];
    assign w_pc_inc    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_jump_taken = (w_op == OP_JZ) ? r_z : ~r_z;
    assign w_unused    = ^{imem_rdata[INSTR_W-5:ADDR_W], r_ir[INSTR_W-5:ADDR_W], r_c};

    alu_seq_decode u_dec (
        .i_op  (w_op),
        .o_dec (w_dec)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (start) w_state_nxt = S_FETCH;
            S_FETCH:        w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (w_dec.needs_mem)                       w_state_nxt = S_MEM;
                else if (w_dec.is_halt)                    w_state_nxt = S_HALT;
                else if (w_dec.is_jump || w_op == OP_NOP)  w_state_nxt = S_FETCH;
                else                                       w_state_nxt = S_EXEC;
            end
            S_MEM:          w_state_nxt = S_EXEC;
            S_EXEC:         w_state_nxt = S_FETCH;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Architectural registers: PC, ACC, IR, operand and flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc   <= '0;
            r_acc  <= '0;
            r_ir   <= '0;
            r_opnd <= '0;
            r_z    <= 1'b0;
            r_c    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: if (start) begin
                    r_pc  <= '0;
                    r_acc <= '0;
                    r_z   <= 1'b0;
                    r_c   <= 1'b0;
                end
                S_DECODE: begin
                    r_ir <= imem_rdata;
                    if (w_dec.is_jump)       r_pc <= w_jump_taken ? w_imm : w_pc_inc;
                    else if (w_op == OP_NOP) r_pc <= w_pc_inc;
                end
                S_MEM: r_opnd <= dmem_rdata;
                S_EXEC: begin
                    if (w_dec.writes_acc) begin
                        r_acc <= alu_result;
                        r_z   <= (alu_result == '0);
                    end
                    if (w_dec.updates_c) r_c <= alu_carry_out;
                    r_pc <= w_pc_inc;
                end
                default: ;
            endcase
        end
    end

    // Memory and ALU control decoded from the current state.
    always_comb begin
        busy      = (r_state != S_IDLE) && (r_state != S_HALT);
        halted    = (r_state == S_HALT);
        imem_addr = r_pc;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        dmem_addr = '0;
        alu_ce    = 1'b0;
        alu_op    = OP_NOP;
        if (w_in_decode && w_dec.needs_mem) begin
            dmem_rd   = 1'b1;
            dmem_addr = w_imm;
        end
        if (w_exec) begin
            alu_ce = 1'b1;
            alu_op = w_op;
            if (w_op == OP_ST) begin
                dmem_wr   = 1'b1;
                dmem_addr = w_imm;
            end
        end
    end

    assign dmem_wdata = r_acc;
    assign alu_left   = r_acc;
    assign alu_right  = r_opnd;
    assign acc        = r_acc;
    assign pc         = r_pc;

`ifdef SALAMANDER_CARRY_CHAIN_EN
    assign alu_carry_in = w_exec && w_dec.updates_c && r_c;
`else
    assign alu_carry_in = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: bench-side memories and ALU model, directed programs.
module tb_alu_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        busy, halted;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [7:0]  dmem_addr;
    logic        dmem_rd, dmem_wr;
    logic [7:0]  dmem_wdata;
    logic [7:0]  dmem_rdata;
    logic        alu_ce;
    logic [3:0]  alu_op;
    logic [7:0]  alu_left, alu_right;
    logic        alu_carry_in;
    logic [7:0]  alu_result;
    logic        alu_carry_out;
    logic [7:0]  acc, pc;

    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    logic [15:0] exp_wr[$];
    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    alu_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy), .halted(halted),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .alu_ce(alu_ce), .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
        .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
        .acc(acc), .pc(pc)
    );

    // Synchronous memories: read data appears the cycle after the address.
    always @(posedge CLK) begin
        imem_rdata <= imem[imem_addr];
        if (dmem_rd) dmem_rdata <= dmem[dmem_addr];
    end

    // Reference ALU (SUB carry_out is the borrow).
    always_comb begin
        alu_result    = 8'h00;
        alu_carry_out = 1'b0;
        case (alu_op)
            4'h0: {alu_carry_out, alu_result} = {1'b0, alu_left} + {1'b0, alu_right} + {8'h00, alu_carry_in};
            4'h1: {alu_carry_out, alu_result} = {1'b0, alu_left} - {1'b0, alu_right} - {8'h00, alu_carry_in};
            4'h2: alu_result = alu_left & alu_right;
            4'h3: alu_result = alu_left | alu_right;
            4'h4: alu_result = alu_left ^ alu_right;
            4'h5: alu_result = ~alu_left;
            4'h6: alu_result = alu_right;
            4'h7: alu_result = alu_left;
            4'h8: alu_result = alu_left + 8'h01;
            4'h9: alu_result = alu_left - 8'h01;
            4'hA: {alu_carry_out, alu_result} = {alu_left, 1'b0};
            4'hB: begin alu_result = alu_left >> 1; alu_carry_out = alu_left[0]; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every data-memory write is popped against the expected queue.
    always @(negedge CLK) begin
        if (RST_N && dmem_rd && dmem_wr) begin
            checks++; failures++;
            $display("FAIL rd_wr_overlap actual=1 expected=0");
        end
        if (RST_N && dmem_wr) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=%02h:%02h expected=none", dmem_addr, dmem_wdata);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                if ({dmem_addr, dmem_wdata} !== e) begin
                    failures++;
                    $display("FAIL dmem_write actual=%02h:%02h expected=%02h:%02h",
                             dmem_addr, dmem_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [7:0] imm);
        return {op, 4'h0, imm};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = ins(4'hC, 8'h00);
    endtask

    // Pulse start, optionally pulse it again mid-run, wait for HALT; returns the halt cycle.
    task automatic run(input int extra_start_at, output int cyc);
        int n;
        @(negedge CLK); start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 0;
        while (!halted && n < 300) begin
            start = (n == extra_start_at);
            @(posedge CLK); #1;
            n++;
        end
        start = 1'b0;
        check("halt_reached", halted, 1);
        cyc = n + 1;
    endtask

    initial begin
        int cyc;
        int n;
        logic [7:0] exp_acc4;
        clear_prog();
        for (int i = 0; i < 256; i++) dmem[i] = 8'hEE;

        // Reset values
        #12;
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_acc", acc, 0);
        check("rst_dmem_ctl", {dmem_rd, dmem_wr, alu_ce, alu_carry_in}, 0);
        check("rst_alu_op_nop", alu_op, 4'hF);
        @(negedge CLK); RST_N = 1'b1;

        // T1: LD/ADD/ST/HLT, with a stray start pulse mid-run that must be ignored
        imem[0] = ins(4'h6, 8'h10); imem[1] = ins(4'h0, 8'h11);
        imem[2] = ins(4'h7, 8'h12); imem[3] = ins(4'hC, 8'h00);
        dmem[8'h10] = 8'h05; dmem[8'h11] = 8'h03;
        exp_wr.push_back({8'h12, 8'h08});
        run(5, cyc);
        check("t1_halt_cycle", cyc, 14);
        check("t1_pc_frozen", pc, 3);
        check("t1_acc", acc, 8'h08);
        check("t1_queue_empty", exp_wr.size(), 0);

        // T2: 0xFF+0x01 -> 0, Z=1, so JZ 0x20 is taken
        clear_prog();
        imem[0] = ins(4'h6, 8'h10); imem[1] = ins(4'h0, 8'h11);
        imem[2] = ins(4'hD, 8'h20); imem[3] = ins(4'h7, 8'h14);
        imem[8'h20] = ins(4'h7, 8'h13);
        dmem[8'h10] = 8'hFF; dmem[8'h11] = 8'h01;
        exp_wr.push_back({8'h13, 8'h00});
        run(-1, cyc);
        check("t2_halt_cycle", cyc, 16);
        check("t2_pc_after_jz", pc, 8'h21);
        check("t2_acc", acc, 8'h00);
        check("t2_queue_empty", exp_wr.size(), 0);

        // T3: 4-4 -> Z=1, JNZ 0x30 not taken, falls through
        clear_prog();
        imem[0] = ins(4'h6, 8'h10); imem[1] = ins(4'h1, 8'h11);
        imem[2] = ins(4'hE, 8'h30); imem[3] = ins(4'h7, 8'h12);
        imem[8'h30] = ins(4'h7, 8'h1F);
        dmem[8'h10] = 8'h04; dmem[8'h11] = 8'h04;
        exp_wr.push_back({8'h12, 8'h00});
        run(-1, cyc);
        check("t3_halt_cycle", cyc, 16);
        check("t3_pc_fallthrough", pc, 8'h04);
        check("t3_queue_empty", exp_wr.size(), 0);

        // T4: set C=1, then 0x01+0x01 with carry chain (0x03) or without (0x02)
`ifdef SALAMANDER_CARRY_CHAIN_EN
        exp_acc4 = 8'h03;
`else
        exp_acc4 = 8'h02;
`endif
        clear_prog();
        imem[0] = ins(4'h6, 8'h10); imem[1] = ins(4'h0, 8'h11);
        imem[2] = ins(4'h6, 8'h15); imem[3] = ins(4'h0, 8'h15);
        imem[4] = ins(4'h7, 8'h16);
        dmem[8'h10] = 8'hFF; dmem[8'h11] = 8'h01; dmem[8'h15] = 8'h01;
        exp_wr.push_back({8'h16, exp_acc4});
        run(-1, cyc);
        check("t4_halt_cycle", cyc, 22);
        check("t4_acc_carry", acc, exp_acc4);
        check("t4_queue_empty", exp_wr.size(), 0);

        // T5: reset during ST's EXEC cycle drops the write immediately
        clear_prog();
        imem[0] = ins(4'h6, 8'h10); imem[1] = ins(4'h7, 8'h12);
        dmem[8'h10] = 8'h5A;
        @(negedge CLK); start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        n = 0;
        while (!dmem_wr && n < 50) begin @(posedge CLK); #2; n++; end
        check("t5_st_exec_seen", dmem_wr, 1);
        RST_N = 1'b0;
        #1;
        check("t5_wr_dropped", {dmem_wr, dmem_rd}, 0);
        check("t5_idle", {busy, halted, alu_ce}, 0);
        check("t5_regs_zero", {pc, acc, dmem_addr, dmem_wdata}, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); RST_N = 1'b1;
        check("t5_no_write", exp_wr.size(), 0);

        // T6: NOP at PC=0xFF wraps to 0x00
        clear_prog();
        imem[0] = ins(4'hE, 8'hFF); imem[8'hFF] = ins(4'hF, 8'h00);
        @(negedge CLK); start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        n = 0;
        while (pc != 8'hFF && n < 20) begin @(posedge CLK); #1; n++; end
        check("t6_jnz_to_ff", pc, 8'hFF);
        n = 0;
        while (pc == 8'hFF && n < 20) begin @(posedge CLK); #1; n++; end
        check("t6_pc_wrap", pc, 8'h00);
        check("t6_imem_addr_wrap", imem_addr, 8'h00);
        @(negedge CLK); RST_N = 1'b0;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
